// File: rtl/freq_meas_pkg.sv
// Shared types and helpers for the multi-channel frequency-measurement scheduler.
package freq_meas_pkg;

   typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

   localparam int unsigned MAX_CH = 64;

   function automatic int unsigned ch_w(input int unsigned n);
      return $clog2(n);
   endfunction

   // First set mask bit strictly after 'last', wrapping; returns 'last' if mask is empty.
   function automatic int unsigned rr_next(input logic [MAX_CH-1:0] mask,
                                           input int unsigned       last,
                                           input int unsigned       n);
      int unsigned idx;
      logic        found;
      rr_next = last;
      found   = 1'b0;
      for (int unsigned k = 1; k <= MAX_CH; k++) begin
         if (k <= n && !found) begin
            idx = last + k;
            if (idx >= n) idx = idx - n;
            if (mask[6'(idx)]) begin
               rr_next = idx;
               found   = 1'b1;
            end
         end
      end
   endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for one asynchronous input followed by a rising-edge pulse.
module edge_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic pulse_c
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], d};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign pulse_c = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/freq_meas_sched.sv
// Round-robin frequency-measurement scheduler: gates one channel at a time and
// counts its rising edges, presenting each result on a valid/ready port.
module freq_meas_sched
   import freq_meas_pkg::*;
#(
   parameter int unsigned  N_CH        = 4,
   parameter int unsigned  CNT_W       = 32,
   parameter int unsigned  GATE_W      = 24,
   parameter int unsigned  SYNC_STAGES = 2,
   localparam int unsigned CH_W        = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [N_CH-1:0]   ch_mask,
   input  logic [GATE_W-1:0] gate_len,
   input  logic [N_CH-1:0]   test_in,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [CH_W-1:0]   res_ch,
   output logic [CNT_W-1:0]  res_count,
   output logic              res_ovf,
   output logic              busy
);

   logic [N_CH-1:0] w_pulse;

   for (genvar g = 0; g < N_CH; g++) begin : g_sync
      edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
         .clk     (clk),
         .rst     (rst),
         .d       (test_in[g]),
         .pulse_c (w_pulse[g])
      );
   end

   state_t             r_state, w_state_nxt;
   logic [CH_W-1:0]    r_last, w_last;
   logic [CH_W-1:0]    r_sel, w_sel;
   logic [GATE_W-1:0]  r_gate, w_gate;
   logic [CNT_W-1:0]   r_cnt, w_cnt;
   logic               r_ovf, w_ovf;
   logic               r_res_valid, w_res_valid;
   logic [CH_W-1:0]    r_res_ch, w_res_ch;
   logic [CNT_W-1:0]   r_res_count, w_res_count;
   logic               r_res_ovf, w_res_ovf;
   logic               r_busy, w_busy;
   logic [CNT_W-1:0]   w_cnt_step;
   logic               w_ovf_step;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_last      = r_last;
      w_sel       = r_sel;
      w_gate      = r_gate;
      w_cnt       = r_cnt;
      w_ovf       = r_ovf;
      w_res_valid = r_res_valid;
      w_res_ch    = r_res_ch;
      w_res_count = r_res_count;
      w_res_ovf   = r_res_ovf;

      // Saturating count of the selected channel's pulse for this cycle.
      w_cnt_step = r_cnt;
      w_ovf_step = r_ovf;
      if (w_pulse[r_sel]) begin
         if (&r_cnt) w_ovf_step = 1'b1;
         else        w_cnt_step = r_cnt + CNT_W'(1);
      end

      case (r_state)
         IDLE: begin
            if (en && (|ch_mask)) begin
               w_sel       = CH_W'(rr_next(MAX_CH'(ch_mask), 32'(r_last), N_CH));
               w_gate      = (gate_len == '0) ? GATE_W'(1) : gate_len;
               w_cnt       = '0;
               w_ovf       = 1'b0;
               w_state_nxt = GATE;
            end
         end
         GATE: begin
            if (!en) begin
               w_state_nxt = IDLE;
            end else if (r_gate == GATE_W'(1)) begin
               w_res_count = w_cnt_step;
               w_res_ovf   = w_ovf_step;
               w_res_ch    = r_sel;
               w_res_valid = 1'b1;
               w_last      = r_sel;
               w_state_nxt = DONE;
            end else begin
               w_gate = r_gate - GATE_W'(1);
               w_cnt  = w_cnt_step;
               w_ovf  = w_ovf_step;
            end
         end
         DONE: begin
            if (res_ready) begin
               w_res_valid = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      w_busy = (w_state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last      <= CH_W'(N_CH - 1);
         r_sel       <= '0;
         r_gate      <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_ch    <= '0;
         r_res_count <= '0;
         r_res_ovf   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_last      <= w_last;
         r_sel       <= w_sel;
         r_gate      <= w_gate;
         r_cnt       <= w_cnt;
         r_ovf       <= w_ovf;
         r_res_valid <= w_res_valid;
         r_res_ch    <= w_res_ch;
         r_res_count <= w_res_count;
         r_res_ovf   <= w_res_ovf;
         r_busy      <= w_busy;
      end
   end

   assign res_valid = r_res_valid;
   assign res_ch    = r_res_ch;
   assign res_count = r_res_count;
   assign res_ovf   = r_res_ovf;
   assign busy      = r_busy;

endmodule

// File: tb/tb_freq_meas_sched.sv
// Randomized scoreboard bench for freq_meas_sched against a cycle-numbered reference model.
module tb_freq_meas_sched;

   localparam int unsigned N_CH   = 4;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned GATE_W = 8;
   localparam int unsigned SYNC   = 2;
   localparam int unsigned CH_W   = 2;
   localparam int          CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic [N_CH-1:0]   ch_mask = '0;
   logic [GATE_W-1:0] gate_len = '0;
   logic [N_CH-1:0]   test_in = '0;
   logic              res_ready = 1'b0;
   logic              res_valid;
   logic [CH_W-1:0]   res_ch;
   logic [CNT_W-1:0]  res_count;
   logic              res_ovf;
   logic              busy;

   freq_meas_sched #(.N_CH(N_CH), .CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(SYNC)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .ch_mask   (ch_mask),
      .gate_len  (gate_len),
      .test_in   (test_in),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_ch    (res_ch),
      .res_count (res_count),
      .res_ovf   (res_ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {int ch; int cnt; bit ovf;} exp_t;
   exp_t sbq[$];

   int n_vec = 0;
   int n_err = 0;
   int n_res = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 idle, 1 gating, 2 result pending. Edges are stored by
   // the cycle in which their synchronized pulse is visible, and a measurement
   // counts those falling inside its gate window [g_start, g_end].
   int              m_mode = 0;
   int              m_last = N_CH - 1;
   int              m_sel = 0;
   int              m_gstart = 0;
   int              m_gend = 0;
   int              m_cyc = 0;
   int              m_since_rst = 0;
   bit              m_armed = 1'b0;
   logic [N_CH-1:0] m_prev_in = '0;
   bit              ev [int];

   always @(posedge clk) begin
      if (rst) begin
         m_mode      = 0;
         m_last      = N_CH - 1;
         m_prev_in   = '0;
         m_since_rst = 0;
         m_armed     = 1'b1;
         sbq.delete();
      end else begin
         m_since_rst++;
         for (int ch = 0; ch < N_CH; ch++)
            if (test_in[ch] && !m_prev_in[ch]) ev[(m_cyc + SYNC) * N_CH + ch] = 1'b1;
         m_prev_in = test_in;
         case (m_mode)
            0: if (en && ch_mask != '0) begin
                  for (int k = 1; k <= N_CH; k++) begin
                     int idx;
                     idx = (m_last + k) % N_CH;
                     if (ch_mask[idx]) begin
                        m_sel = idx;
                        break;
                     end
                  end
                  m_gstart = m_cyc + 1;
                  m_gend   = m_cyc + ((gate_len == '0) ? 1 : int'(gate_len));
                  m_mode   = 1;
               end
            1: if (!en) begin
                  m_mode = 0;
               end else if (m_cyc == m_gend) begin
                  exp_t e;
                  int   c;
                  c = 0;
                  for (int t = m_gstart; t <= m_gend; t++)
                     if (ev.exists(t * N_CH + m_sel)) c++;
                  e.ch  = m_sel;
                  e.cnt = (c > CMAX) ? CMAX : c;
                  e.ovf = (c > CMAX);
                  sbq.push_back(e);
                  m_last = m_sel;
                  m_mode = 2;
               end
            default: if (res_ready) m_mode = 0;
         endcase
      end
      m_cyc++;
   end

   // Monitor: compares DUT outputs every cycle against the model and scoreboard head.
   always @(negedge clk) begin
      if (m_armed) begin
         chk("busy", busy, (m_mode != 0));
         chk("res_valid", res_valid, (m_mode == 2));
         if (m_since_rst == 0) begin
            chk("rst_res_count", res_count, 0);
            chk("rst_res_ch", res_ch, 0);
            chk("rst_res_ovf", res_ovf, 0);
         end
         if (res_valid) begin
            if (sbq.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               chk("res_ch", res_ch, sbq[0].ch);
               chk("res_count", res_count, sbq[0].cnt);
               chk("res_ovf", res_ovf, sbq[0].ovf);
               if (res_ready) begin
                  void'(sbq.pop_front());
                  n_res++;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int t;
      rst = 1'b1;
      repeat (4) tick();
      rst = 1'b0;

      // Single channel, 10-cycle test period over a 100-cycle gate.
      en = 1'b1; ch_mask = 4'b0001; gate_len = 8'd100; res_ready = 1'b1;
      for (int i = 0; i < 250; i++) begin
         test_in = {3'b000, ((i % 10) < 5)};
         tick();
      end

      // Empty mask with enable held high.
      ch_mask = '0; test_in = '0;
      repeat (100) tick();

      // Round robin over channels 0,1,3.
      ch_mask = 4'b1011; gate_len = 8'd10;
      for (int i = 0; i < 150; i++) begin
         test_in = N_CH'($urandom);
         tick();
      end

      // Random traffic: mask, gate length, enable drops and back-pressure.
      for (int i = 0; i < 3000; i++) begin
         test_in = N_CH'($urandom);
         if ($urandom_range(0, 49) == 0) ch_mask = N_CH'($urandom);
         gate_len  = ($urandom_range(0, 1) == 1) ? GATE_W'($urandom_range(0, 100))
                                                 : GATE_W'($urandom_range(0, 8));
         en        = ($urandom_range(0, 199) != 0);
         res_ready = (i % 400 < 60) ? 1'b0 : ($urandom_range(0, 3) != 0);
         tick();
      end

      // Reset while a result is pending; channel 0 must come first afterwards.
      en = 1'b1; ch_mask = 4'b1111; gate_len = 8'd5; test_in = '0; res_ready = 1'b1;
      repeat (10) tick();
      res_ready = 1'b0;
      t = 0;
      while (m_mode != 2 && t < 100) begin
         tick();
         t++;
      end
      chk("wait_done", (m_mode == 2), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      res_ready = 1'b1;
      repeat (40) tick();

      chk("results_seen", (n_res > 20), 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
